// File: rtl/stat_calc_pkg.sv
// stat_calc_pkg: state encoding, select codes and width
// helpers shared by the statistics engine and its divider.
package stat_calc_pkg;

  typedef enum logic [2:0] {
    IDLE,
    COLLECT,
    DIV_AVG,
    DIV_VAR,
    SQRT,
    DONE
  } state_t;

  localparam logic [1:0] SEL_SUM   = 2'b00;
  localparam logic [1:0] SEL_AVG   = 2'b01;
  localparam logic [1:0] SEL_SUMSQ = 2'b10;
  localparam logic [1:0] SEL_STD   = 2'b11;

  function automatic int sum_w(input int dw, input int cw);
    return dw + cw;
  endfunction

  function automatic int sq_w(input int dw, input int cw);
    return 2 * dw + cw;
  endfunction

  function automatic int num_w(input int dw, input int cw);
    return 2 * dw + 2 * cw;
  endfunction

endpackage

// File: rtl/seq_divider.sv
// seq_divider: restoring unsigned divider, one quotient bit
// per cycle; done pulses WIDTH+1 cycles after start.
module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH-1:0] o_quotient,
  output logic             o_busy,
  output logic             o_done
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_dvs;
  logic [CW-1:0]    r_cnt;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_diff;
  logic             w_ge;

  // A zero divisor always "fits", so the quotient saturates to all ones.
  always_comb begin
    w_shift = {r_rem, r_quo[WIDTH-1]};
    w_ge    = (w_shift >= {1'b0, r_dvs});
    w_diff  = w_shift - {1'b0, r_dvs};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rem  <= '0;
      r_quo  <= '0;
      r_dvs  <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (i_start) begin
        r_rem  <= '0;
        r_quo  <= i_dividend;
        r_dvs  <= i_divisor;
        r_cnt  <= CW'(WIDTH);
        r_busy <= 1'b1;
      end else if (r_busy) begin
        r_rem <= w_ge ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
        r_quo <= {r_quo[WIDTH-2:0], w_ge};
        r_cnt <= r_cnt - 1'b1;
        if (r_cnt == CW'(1)) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end
      end
    end
  end

  assign o_quotient = r_quo;
  assign o_busy     = r_busy;
  assign o_done     = r_done;

endmodule

// File: rtl/stat_calc_engine.sv
// stat_calc_engine: collects N samples, then derives AVG and
// STD with a shared divider and an iterative square root.
module stat_calc_engine
  import stat_calc_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8,
  parameter int OUT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_enter_btn,
  input  logic              i_show_btn,
  input  logic [1:0]        i_sel,
  input  logic [DATA_W-1:0] i_din,
  output logic [OUT_W-1:0]  o_led,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_ovf
);

  localparam int SUM_W = sum_w(DATA_W, CNT_W);
  localparam int SQ_W  = sq_w(DATA_W, CNT_W);
  localparam int NUM_W = num_w(DATA_W, CNT_W);
  localparam int RT_W  = NUM_W / 2;
  localparam int SC_W  = $clog2(RT_W + 1);
  localparam int ST_W  = (SQ_W > OUT_W) ? SQ_W : OUT_W;

  state_t r_state, w_nxt;

  logic              r_enter_q, r_show_q;
  logic              w_enter_p, w_show_p;
  logic [CNT_W-1:0]  r_n, r_left, w_din_cnt;
  logic [SUM_W-1:0]  r_sum, r_avg;
  logic [SQ_W-1:0]   r_sumsq, w_sq_in;
  logic [RT_W-1:0]   r_std;
  logic [NUM_W-1:0]  r_num, r_den, w_num, w_den;
  logic              r_start, r_ovf;
  logic [OUT_W-1:0]  r_led;
  logic              w_start_run, w_take;
  logic [NUM_W-1:0]  w_dividend, w_divisor, w_quo;
  logic              w_div_busy, w_div_done;
  logic [NUM_W-1:0]  r_sq_val;
  logic [RT_W-1:0]   r_sq_rem, r_sq_root, w_sq_root;
  logic [RT_W+1:0]   w_sq_pull, w_sq_trial;
  logic              w_sq_ge;
  logic [SC_W-1:0]   r_sq_cnt;
  logic [ST_W-1:0]   w_stat;

  assign w_enter_p = i_enter_btn & ~r_enter_q;
  assign w_show_p  = i_show_btn & ~r_show_q;
  assign w_din_cnt = CNT_W'(i_din);
  assign w_sq_in   = SQ_W'(i_din) * SQ_W'(i_din);

  assign w_start_run = w_enter_p && (w_din_cnt != '0) &&
                       ((r_state == IDLE) || (r_state == DONE));
  assign w_take = w_enter_p && (r_state == COLLECT) &&
                  (r_left != '0);

  assign w_num = NUM_W'(r_n) * NUM_W'(r_sumsq) -
                 NUM_W'(r_sum) * NUM_W'(r_sum);
  assign w_den = NUM_W'(r_n) * NUM_W'(r_n);

  assign w_dividend = (r_state == DIV_VAR) ? r_num : NUM_W'(r_sum);
  assign w_divisor  = (r_state == DIV_VAR) ? r_den : NUM_W'(r_n);

  seq_divider #(.WIDTH(NUM_W)) u_div (
    .clk        (clk),
    .rst        (rst),
    .i_start    (r_start),
    .i_dividend (w_dividend),
    .i_divisor  (w_divisor),
    .o_quotient (w_quo),
    .o_busy     (w_div_busy),
    .o_done     (w_div_done)
  );

  // Digit-by-digit root: bring down two radicand bits per cycle.
  always_comb begin
    w_sq_pull  = {r_sq_rem, r_sq_val[NUM_W-1 -: 2]};
    w_sq_trial = {r_sq_root, 2'b01};
    w_sq_ge    = (w_sq_pull >= w_sq_trial);
    w_sq_root  = {r_sq_root[RT_W-2:0], w_sq_ge};
  end

  always_comb begin
    w_nxt = r_state;
    unique case (r_state)
      IDLE, DONE: if (w_start_run) w_nxt = COLLECT;
      COLLECT:
        if (w_take && (r_left == CNT_W'(1))) w_nxt = DIV_AVG;
      DIV_AVG: if (w_div_done) w_nxt = DIV_VAR;
      DIV_VAR: if (w_div_done) w_nxt = SQRT;
      SQRT: if (r_sq_cnt == SC_W'(1)) w_nxt = DONE;
      default: w_nxt = IDLE;
    endcase
  end

  // AVG and STD stay hidden until the whole run has finished.
  always_comb begin
    w_stat = '0;
    unique case (i_sel)
      SEL_SUM:   w_stat = ST_W'(r_sum);
      SEL_AVG:   w_stat = (r_state == DONE) ? ST_W'(r_avg) : '0;
      SEL_SUMSQ: w_stat = ST_W'(r_sumsq);
      SEL_STD:   w_stat = (r_state == DONE) ? ST_W'(r_std) : '0;
      default:   w_stat = '0;
    endcase
  end

  if (ST_W > OUT_W) begin : g_hi
    logic w_unused_hi;
    assign w_unused_hi = ^w_stat[ST_W-1:OUT_W];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_enter_q <= 1'b0;
      r_show_q  <= 1'b0;
      r_n       <= '0;
      r_left    <= '0;
      r_sum     <= '0;
      r_sumsq   <= '0;
      r_avg     <= '0;
      r_std     <= '0;
      r_num     <= '0;
      r_den     <= '0;
      r_start   <= 1'b0;
      r_ovf     <= 1'b0;
      r_led     <= '0;
      r_sq_val  <= '0;
      r_sq_rem  <= '0;
      r_sq_root <= '0;
      r_sq_cnt  <= '0;
    end else begin
      r_state   <= w_nxt;
      r_enter_q <= i_enter_btn;
      r_show_q  <= i_show_btn;
      r_start   <= ((w_nxt == DIV_AVG) && (r_state != DIV_AVG)) ||
                   ((w_nxt == DIV_VAR) && (r_state != DIV_VAR));
      if (w_show_p) r_led <= w_stat[OUT_W-1:0];
      if (w_start_run) begin
        r_n     <= w_din_cnt;
        r_left  <= w_din_cnt;
        r_sum   <= '0;
        r_sumsq <= '0;
        r_avg   <= '0;
        r_std   <= '0;
        r_ovf   <= 1'b0;
      end
      if (w_take) begin
        r_sum   <= r_sum + SUM_W'(i_din);
        r_sumsq <= r_sumsq + w_sq_in;
        r_left  <= r_left - 1'b1;
      end
      if (w_enter_p && (r_state == COLLECT) && (r_left == '0))
        r_ovf <= 1'b1;
      if ((r_state == DIV_AVG) && w_div_done) begin
        r_avg <= SUM_W'(w_quo);
        r_num <= w_num;
        r_den <= w_den;
      end
      if ((r_state == DIV_VAR) && w_div_done) begin
        r_sq_val  <= w_quo;
        r_sq_rem  <= '0;
        r_sq_root <= '0;
        r_sq_cnt  <= SC_W'(RT_W);
      end
      if (r_state == SQRT) begin
        r_sq_val  <= {r_sq_val[NUM_W-3:0], 2'b00};
        r_sq_rem  <= RT_W'(w_sq_ge ? w_sq_pull - w_sq_trial
                                   : w_sq_pull);
        r_sq_root <= w_sq_root;
        r_sq_cnt  <= r_sq_cnt - 1'b1;
        if (r_sq_cnt == SC_W'(1)) r_std <= w_sq_root;
      end
    end
  end

  assign o_led  = r_led;
  assign o_busy = (r_state == DIV_AVG) || (r_state == DIV_VAR) ||
                  (r_state == SQRT) || w_div_busy;
  assign o_done = (r_state == DONE);
  assign o_ovf  = r_ovf;

endmodule

// File: tb/tb_stat_calc_engine.sv
// Bench for stat_calc_engine: show presses and done edges are
// scored against an arithmetic model through expectation queues.
module tb_stat_calc_engine;

  localparam int DATA_W = 8;
  localparam int CNT_W  = 8;
  localparam int OUT_W  = 8;
  localparam int NUM_W  = 2 * DATA_W + 2 * CNT_W;
  localparam int LAT    = 2 * (NUM_W + 2) + NUM_W / 2 + 1;
  localparam longint MASK = (64'd1 << OUT_W) - 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              enter = 1'b0;
  logic              show = 1'b0;
  logic [1:0]        sel = 2'b00;
  logic [DATA_W-1:0] din = '0;
  logic [OUT_W-1:0]  led;
  logic              busy, done, ovf;

  int     n_chk = 0;
  int     n_fail = 0;
  longint cyc = 0;
  longint t_last = 0;
  longint last_drive = 0;
  longint led_q[$];
  longint lat_q[$];

  always #5 clk = ~clk;

  stat_calc_engine #(
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W),
    .OUT_W  (OUT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .i_enter_btn (enter),
    .i_show_btn  (show),
    .i_sel       (sel),
    .i_din       (din),
    .o_led       (led),
    .o_busy      (busy),
    .o_done      (done),
    .o_ovf       (ovf)
  );

  task automatic check(input string nm, input longint act,
                       input longint exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic press_enter(input int v);
    @(negedge clk);
    din = DATA_W'(v);
    enter = 1'b1;
    last_drive = cyc;
    @(negedge clk);
    enter = 1'b0;
  endtask

  task automatic press_show(input int s, input longint exp);
    @(negedge clk);
    sel = 2'(s);
    show = 1'b1;
    led_q.push_back(exp & MASK);
    @(negedge clk);
    show = 1'b0;
  endtask

  task automatic wait_done();
    int i;
    i = 0;
    while (!done && i < 400) begin
      @(negedge clk);
      i++;
    end
    check("done_reached", longint'(done), 1);
  endtask

  // Reference: plain integer statistics over the sample list.
  task automatic sweep(input int s[$]);
    longint n, sum, sq, avg, vr, sd;
    n = s.size();
    sum = 0;
    sq = 0;
    sd = 0;
    foreach (s[i]) begin
      sum += s[i];
      sq += longint'(s[i]) * s[i];
    end
    avg = sum / n;
    vr = (n * sq - sum * sum) / (n * n);
    while ((sd + 1) * (sd + 1) <= vr) sd++;
    press_show(0, sum);
    press_show(1, avg);
    press_show(2, sq);
    press_show(3, sd);
  endtask

  task automatic do_run(input int s[$], input bit poke);
    press_enter(s.size());
    foreach (s[i]) press_enter(s[i]);
    t_last = last_drive;
    lat_q.push_back(LAT);
    if (poke) begin
      check("busy_after_last", longint'(busy), 1);
      repeat (3) press_enter(3);
    end
    wait_done();
    sweep(s);
    check("ovf_clear", longint'(ovf), 0);
  endtask

  initial begin : monitor
    bit sp, dp, pend;
    longint e;
    sp = 1'b0;
    dp = 1'b0;
    forever begin
      @(posedge clk);
      cyc++;
      pend = show && !sp && !rst;
      sp = show;
      @(negedge clk);
      if (pend) begin
        if (led_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL led_unexpected: got %0d, expected none", led);
        end else begin
          e = led_q.pop_front();
          check("led", longint'(led), e);
        end
      end
      if (done && !dp) begin
        if (lat_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL done_unexpected: got 1, expected 0");
        end else begin
          e = lat_q.pop_front();
          check("latency", cyc - t_last, e);
        end
      end
      dp = done;
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end

  initial begin : stim
    int q[$];
    repeat (3) @(negedge clk);
    check("rst_led", longint'(led), 0);
    check("rst_busy", longint'(busy), 0);
    check("rst_done", longint'(done), 0);
    check("rst_ovf", longint'(ovf), 0);
    rst = 1'b0;

    @(negedge clk);
    din = '0;
    enter = 1'b1;
    repeat (50) @(negedge clk);
    enter = 1'b0;
    check("zero_cnt_busy", longint'(busy), 0);
    check("zero_cnt_done", longint'(done), 0);
    press_show(0, 0);

    press_enter(2);
    @(negedge clk);
    din = 8'd5;
    enter = 1'b1;
    repeat (50) @(negedge clk);
    enter = 1'b0;
    check("held_busy", longint'(busy), 0);
    press_show(0, 5);
    press_show(1, 0);
    press_enter(9);
    t_last = last_drive;
    lat_q.push_back(LAT);
    wait_done();
    q = {5, 9};
    sweep(q);

    q = {2, 4, 4, 6};
    do_run(q, 1'b1);
    q = {10, 10, 10};
    do_run(q, 1'b0);
    q = {0, 255};
    do_run(q, 1'b0);

    press_enter(3);
    press_enter(20);
    @(negedge clk);
    din = 8'd30;
    enter = 1'b1;
    sel = 2'b00;
    show = 1'b1;
    led_q.push_back(20);
    @(negedge clk);
    enter = 1'b0;
    show = 1'b0;
    press_show(0, 50);
    press_show(3, 0);
    press_enter(40);
    t_last = last_drive;
    lat_q.push_back(LAT);
    wait_done();
    q = {20, 30, 40};
    sweep(q);

    q.delete();
    for (int i = 0; i < 255; i++) q.push_back(255);
    do_run(q, 1'b0);

    repeat (6) begin
      int n;
      q.delete();
      n = $urandom_range(1, 12);
      for (int i = 0; i < n; i++) q.push_back($urandom_range(0, 255));
      do_run(q, 1'($urandom_range(0, 1)));
    end

    press_enter(2);
    press_enter(100);
    press_show(0, 100);
    press_enter(50);
    repeat (NUM_W + 2 + 5) @(negedge clk);
    check("mid_var_busy", longint'(busy), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_led", longint'(led), 0);
    check("abort_busy", longint'(busy), 0);
    check("abort_done", longint'(done), 0);
    check("abort_ovf", longint'(ovf), 0);
    q = {7};
    do_run(q, 1'b0);

    repeat (5) @(negedge clk);
    check("led_q_drained", longint'(led_q.size()), 0);
    check("lat_q_drained", longint'(lat_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
